// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the fetch stage
//   (instruction reads) and the memory stage (data loads/stores).
//   One requester is granted at a time. The grant drives a registered
//   req/ack memory handshake. Completion is a one-cycle ready pulse back
//   to the granted port.
//   Stores get byte enables and lane-replicated write data.
//   Loads are lane-selected and then sign- or zero-extended.
//
// Build option:
//   MEMARB_RR_EN  defined   : two-way round-robin on simultaneous requests
//                 undefined : strict priority to the data port
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ireqF/iaddrF      fetch request and byte address
//   instrF/ireadyF    fetched instruction, one-cycle completion pulse
//   dreqM/dwriteM     data request, 1 = store / 0 = load
//   daddrM/dwdataM    data byte address, right-aligned store data
//   dsizeM            00 word, 01 half, 10 byte, 11 word
//   dunsignedM        zero-extend loads when 1
//   drdataM/dreadyM   extended load data, one-cycle completion pulse
//   mreq/mwe/maddr    memory request, write enable, word-aligned address
//   mwdata/mbe        replicated store data, byte enables
//   mrdata/mack       memory read data, completion (valid while mreq)
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireqF,
    input  logic [AW-1:0] iaddrF,
    output logic [DW-1:0] instrF,
    output logic          ireadyF,
    input  logic          dreqM,
    input  logic          dwriteM,
    input  logic [AW-1:0] daddrM,
    input  logic [DW-1:0] dwdataM,
    input  logic [1:0]    dsizeM,
    input  logic          dunsignedM,
    output logic [DW-1:0] drdataM,
    output logic          dreadyM,
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mwdata,
    output logic [3:0]    mbe,
    input  logic [DW-1:0] mrdata,
    input  logic          mack
);

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_e;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_e;

    state_e      state;
    grant_e      lastGrant;

    // Attributes of the granted data access, needed again when mack arrives
    logic [1:0]  latAddrLo;
    logic [1:0]  latSize;
    logic        latUnsigned;
    logic        latWrite;

    logic        pickData;
    logic [3:0]  storeBe;
    logic [DW-1:0] storeData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [DW-1:0] loadData;

    // Fetch addresses are word-aligned by the memory; low bits are dropped
    logic        unusedIaddrLo;
    assign unusedIaddrLo = ^iaddrF[1:0];

`ifdef MEMARB_RR_EN
    // Alternate on contention; a lone request always wins
    assign pickData = dreqM && (!ireqF || (lastGrant == GRANT_FETCH));
`else
    // Data always wins; lastGrant is kept only for the round-robin build
    logic unusedLastGrant;
    assign pickData        = dreqM;
    assign unusedLastGrant = (lastGrant == GRANT_DATA);
`endif

    // Store lanes from the live request, captured at grant
    always_comb begin
        storeBe   = 4'b1111;
        storeData = dwdataM;
        case (dsizeM)
            SIZE_HALF: begin
                storeBe   = daddrM[1] ? 4'b1100 : 4'b0011;
                storeData = {2{dwdataM[15:0]}};
            end
            SIZE_BYTE: begin
                storeBe   = 4'b0001 << daddrM[1:0];
                storeData = {4{dwdataM[7:0]}};
            end
            default: begin
                storeBe   = 4'b1111;
                storeData = dwdataM;
            end
        endcase
    end

    // Load lane selection and extension from the latched access attributes
    always_comb begin
        loadByte = mrdata[7:0];
        loadHalf = latAddrLo[1] ? mrdata[31:16] : mrdata[15:0];
        loadData = mrdata;
        case (latAddrLo)
            2'd0: loadByte = mrdata[7:0];
            2'd1: loadByte = mrdata[15:8];
            2'd2: loadByte = mrdata[23:16];
            2'd3: loadByte = mrdata[31:24];
            default: loadByte = mrdata[7:0];
        endcase
        case (latSize)
            SIZE_BYTE: loadData = latUnsigned ? {24'b0, loadByte}
                                              : {{24{loadByte[7]}}, loadByte};
            SIZE_HALF: loadData = latUnsigned ? {16'b0, loadHalf}
                                              : {{16{loadHalf[15]}}, loadHalf};
            default:   loadData = mrdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lastGrant   <= GRANT_FETCH;
            mreq        <= 1'b0;
            mwe         <= 1'b0;
            maddr       <= '0;
            mwdata      <= '0;
            mbe         <= '0;
            instrF      <= '0;
            drdataM     <= '0;
            ireadyF     <= 1'b0;
            dreadyM     <= 1'b0;
            latAddrLo   <= '0;
            latSize     <= '0;
            latUnsigned <= 1'b0;
            latWrite    <= 1'b0;
        end else begin
            ireadyF <= 1'b0;
            dreadyM <= 1'b0;
            case (state)
                IDLE: begin
                    // A ready pulse means the requester has not yet dropped
                    // its request; granting now would serve it twice.
                    if (!ireadyF && !dreadyM && (ireqF || dreqM)) begin
                        mreq <= 1'b1;
                        if (pickData) begin
                            state       <= DATA;
                            maddr       <= {daddrM[AW-1:2], 2'b00};
                            mwe         <= dwriteM;
                            mbe         <= dwriteM ? storeBe : 4'b1111;
                            mwdata      <= storeData;
                            latAddrLo   <= daddrM[1:0];
                            latSize     <= dsizeM;
                            latUnsigned <= dunsignedM;
                            latWrite    <= dwriteM;
                        end else begin
                            state    <= FETCH;
                            maddr    <= {iaddrF[AW-1:2], 2'b00};
                            mwe      <= 1'b0;
                            mbe      <= 4'b1111;
                            mwdata   <= '0;
                            latWrite <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (mack) begin
                        state     <= IDLE;
                        mreq      <= 1'b0;
                        instrF    <= mrdata;
                        ireadyF   <= 1'b1;
                        lastGrant <= GRANT_FETCH;
                    end
                end
                DATA: begin
                    if (mack) begin
                        state     <= IDLE;
                        mreq      <= 1'b0;
                        mwe       <= 1'b0;
                        dreadyM   <= 1'b1;
                        lastGrant <= GRANT_DATA;
                        if (!latWrite) begin
                            drdataM <= loadData;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    mreq  <= 1'b0;
                    mwe   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: reset state, fetch and data
//   handshakes, store lanes, load extension, reset during a transaction and
//   arbitration under contention (both build options via MEMARB_RR_EN).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireqF;
    logic [31:0] iaddrF;
    logic [31:0] instrF;
    logic        ireadyF;
    logic        dreqM;
    logic        dwriteM;
    logic [31:0] daddrM;
    logic [31:0] dwdataM;
    logic [1:0]  dsizeM;
    logic        dunsignedM;
    logic [31:0] drdataM;
    logic        dreadyM;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic [31:0] mrdata;
    logic        mack;

    int checks = 0;
    int errors = 0;
    int respCnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .ireqF(ireqF), .iaddrF(iaddrF), .instrF(instrF), .ireadyF(ireadyF),
        .dreqM(dreqM), .dwriteM(dwriteM), .daddrM(daddrM), .dwdataM(dwdataM),
        .dsizeM(dsizeM), .dunsignedM(dunsignedM), .drdataM(drdataM), .dreadyM(dreadyM),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mbe(mbe),
        .mrdata(mrdata), .mack(mack)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory that acks in the second cycle of each request
    task automatic memResp();
        if (mreq) begin
            respCnt++;
            mack   = (respCnt == 2);
            mrdata = 32'h0BAD_F00D;
        end else begin
            respCnt = 0;
            mack    = 1'b0;
        end
    endtask

    // Called at a negedge with the arbiter idle; ack in the first mreq cycle
    task automatic runFetch(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
        ireqF  = 1'b1;
        iaddrF = addr;
        @(negedge clk);
        checkEq($sformatf("%s.mreq1", tag), mreq, 1);
        checkEq($sformatf("%s.maddr", tag), maddr, {addr[31:2], 2'b00});
        checkEq($sformatf("%s.mbe", tag), mbe, 4'b1111);
        checkEq($sformatf("%s.mwe", tag), mwe, 0);
        mack   = 1'b1;
        mrdata = rdata;
        @(negedge clk);
        mack  = 1'b0;
        ireqF = 1'b0;
        checkEq($sformatf("%s.ready", tag), ireadyF, 1);
        checkEq($sformatf("%s.instr", tag), instrF, rdata);
        checkEq($sformatf("%s.mreq2", tag), mreq, 0);
        @(negedge clk);
        checkEq($sformatf("%s.readyOff", tag), ireadyF, 0);
        checkEq($sformatf("%s.instrHold", tag), instrF, rdata);
    endtask

    task automatic runData(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input logic [31:0] expRd);
        dreqM      = 1'b1;
        dwriteM    = wr;
        daddrM     = addr;
        dwdataM    = wdata;
        dsizeM     = size;
        dunsignedM = uns;
        @(negedge clk);
        checkEq($sformatf("%s.mreq1", tag), mreq, 1);
        checkEq($sformatf("%s.maddr", tag), maddr, {addr[31:2], 2'b00});
        checkEq($sformatf("%s.mbe", tag), mbe, expBe);
        checkEq($sformatf("%s.mwe", tag), mwe, wr);
        if (wr) checkEq($sformatf("%s.mwdata", tag), mwdata, expWdata);
        mack   = 1'b1;
        mrdata = rdata;
        @(negedge clk);
        mack  = 1'b0;
        dreqM = 1'b0;
        checkEq($sformatf("%s.ready", tag), dreadyM, 1);
        checkEq($sformatf("%s.rdata", tag), drdataM, expRd);
        checkEq($sformatf("%s.mreq2", tag), mreq, 0);
        @(negedge clk);
        checkEq($sformatf("%s.readyOff", tag), dreadyM, 0);
        checkEq($sformatf("%s.rdataHold", tag), drdataM, expRd);
    endtask

    initial begin
        logic [31:0] expI;
        logic [31:0] expD;
        logic        gotFetch;
        logic        strayData;

        reset = 1'b1; ireqF = 1'b0; iaddrF = '0; dreqM = 1'b0; dwriteM = 1'b0;
        daddrM = '0; dwdataM = '0; dsizeM = '0; dunsignedM = 1'b0; mrdata = '0; mack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkEq("rst.mreq", mreq, 0);
        checkEq("rst.mwe", mwe, 0);
        checkEq("rst.mbe", mbe, 0);
        checkEq("rst.maddr", maddr, 0);
        checkEq("rst.mwdata", mwdata, 0);
        checkEq("rst.instrF", instrF, 0);
        checkEq("rst.drdataM", drdataM, 0);
        checkEq("rst.ireadyF", ireadyF, 0);
        checkEq("rst.dreadyM", dreadyM, 0);

        runFetch("fetch40", 32'h40, 32'h2002_0005);

        // Loads against 0x80FF_7F01
        runData("ldB3s", 0, 32'h003, '0, 2'b10, 0, 32'h80FF_7F01, 4'b1111, '0, 32'hFFFF_FF80);
        runData("ldB3u", 0, 32'h003, '0, 2'b10, 1, 32'h80FF_7F01, 4'b1111, '0, 32'h0000_0080);
        runData("ldB1s", 0, 32'h001, '0, 2'b10, 0, 32'h80FF_7F01, 4'b1111, '0, 32'h0000_007F);
        runData("ldB2u", 0, 32'h002, '0, 2'b10, 1, 32'h80FF_7F01, 4'b1111, '0, 32'h0000_00FF);
        runData("ldH0s", 0, 32'h000, '0, 2'b01, 0, 32'h80FF_7F01, 4'b1111, '0, 32'h0000_7F01);
        runData("ldH2s", 0, 32'h002, '0, 2'b01, 0, 32'h80FF_7F01, 4'b1111, '0, 32'hFFFF_80FF);
        runData("ldH6u", 0, 32'h006, '0, 2'b01, 1, 32'h80FF_7F01, 4'b1111, '0, 32'h0000_80FF);
        runData("ldWmis", 0, 32'h207, '0, 2'b00, 0, 32'h80FF_7F01, 4'b1111, '0, 32'h80FF_7F01);

        // Stores leave drdataM at the last load value
        runData("stB103", 1, 32'h103, 32'h0000_00AB, 2'b10, 0, 32'hDEAD_0000, 4'b1000, 32'hABAB_ABAB, 32'h80FF_7F01);
        runData("stB101", 1, 32'h101, 32'h0000_005C, 2'b10, 0, 32'hDEAD_0000, 4'b0010, 32'h5C5C_5C5C, 32'h80FF_7F01);
        runData("stH102", 1, 32'h102, 32'hFFFF_1234, 2'b01, 0, 32'hDEAD_0000, 4'b1100, 32'h1234_1234, 32'h80FF_7F01);
        runData("stH100", 1, 32'h100, 32'h0000_5678, 2'b01, 0, 32'hDEAD_0000, 4'b0011, 32'h5678_5678, 32'h80FF_7F01);
        runData("stW11", 1, 32'h300, 32'hCAFE_F00D, 2'b11, 0, 32'hDEAD_0000, 4'b1111, 32'hCAFE_F00D, 32'h80FF_7F01);

        // Reset while a load is outstanding; the ack arrives after release
        dreqM = 1'b1; dwriteM = 1'b0; daddrM = 32'h10; dsizeM = 2'b00; dunsignedM = 1'b0;
        @(negedge clk);
        checkEq("rstMid.mreqBefore", mreq, 1);
        #1 reset = 1'b1;
        dreqM = 1'b0;
        #1 checkEq("rstMid.mreqAsync", mreq, 0);
        @(negedge clk);
        reset  = 1'b0;
        mack   = 1'b1;
        mrdata = 32'h1234_5678;
        @(negedge clk);
        checkEq("rstMid.noReady1", dreadyM, 0);
        checkEq("rstMid.mreqLow1", mreq, 0);
        checkEq("rstMid.drdata", drdataM, 0);
        @(negedge clk);
        checkEq("rstMid.noReady2", dreadyM, 0);
        checkEq("rstMid.mreqLow2", mreq, 0);
        mack = 1'b0;
        runFetch("postRst", 32'h80, 32'h2442_0001);

        // Contention with ack latency 2: ready pulses at cycles 3, 7, 11, 15
        dreqM = 1'b1; dwriteM = 1'b0; daddrM = 32'h20; dsizeM = 2'b00;
        ireqF = 1'b1; iaddrF = 32'h44;
        respCnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            memResp();
            expI = '0;
            expD = '0;
            if (c % 4 == 3) begin
`ifdef MEMARB_RR_EN
                if ((c / 4) % 2 == 0) expD = 1; else expI = 1;
`else
                expD = 1;
`endif
            end
            checkEq($sformatf("arb.c%0d.dready", c), dreadyM, expD);
            checkEq($sformatf("arb.c%0d.iready", c), ireadyF, expI);
        end
        dreqM = 1'b0;
        gotFetch  = 1'b0;
        strayData = 1'b0;
        for (int c = 0; c < 10 && !gotFetch; c++) begin
            @(negedge clk);
            memResp();
            if (dreadyM) strayData = 1'b1;
            if (ireadyF) gotFetch = 1'b1;
        end
        ireqF = 1'b0;
        mack  = 1'b0;
        checkEq("arb.fetchAfterDrop", gotFetch, 1);
        checkEq("arb.noDataAfterDrop", strayData, 0);
        checkEq("arb.fetchInstr", instrF, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
